// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// Sits behind message_printer. tx_busy holds the printer off while the FIFO
// is full or the host asserts block. block only gates the start of a frame.
module serial_tx_fifo #(
  parameter int CLK_PER_BIT = 50,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       tx_busy,
  output logic       overflow,
  output logic       tx
);

  localparam int TIMER_W = $clog2(CLK_PER_BIT);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             wr_en;
  logic             pop;

  // Transmitter state
  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [TIMER_W-1:0] bit_timer;
  logic [TIMER_W-1:0] bit_timer_next;
  logic [2:0]         bit_idx;
  logic [2:0]         bit_idx_next;
  logic [7:0]         shift;
  logic [7:0]         shift_next;
  logic               tx_next;
  logic               timer_done;
  logic               can_start;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  // A full FIFO rejects the write even when a pop happens in the same cycle.
  assign wr_en = new_data && !fifo_full;

  assign tx_busy = fifo_full || block;

  assign timer_done = (bit_timer == TIMER_LAST);

  // A new frame may only begin when there is data and the host permits it.
  assign can_start = !fifo_empty && !block;

  // Next-state logic for the frame sequencer; tx_next is the value the line
  // takes at the same edge as the state change, so tx stays a clean register.
  always_comb begin
    state_next     = state;
    bit_timer_next = bit_timer + TIMER_W'(1);
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    tx_next        = tx;
    pop            = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_next        = 1'b1;
        bit_timer_next = '0;
        if (can_start) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = ST_START;
          tx_next    = 1'b0;
        end
      end

      ST_START: begin
        if (timer_done) begin
          bit_timer_next = '0;
          bit_idx_next   = '0;
          state_next     = ST_DATA;
          tx_next        = shift[0];
        end
      end

      ST_DATA: begin
        if (timer_done) begin
          bit_timer_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (timer_done) begin
          bit_timer_next = '0;
          if (can_start) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = ST_START;
            tx_next    = 1'b0;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end
      end

      default: begin
        state_next     = ST_IDLE;
        bit_timer_next = '0;
        tx_next        = 1'b1;
      end
    endcase
  end

  // Register the sequencer; reset drops any frame in flight and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      bit_timer <= bit_timer_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      tx        <= tx_next;
    end
  end

  // Pointer, occupancy and sticky overflow tracking; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (new_data && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Byte storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data;
    end
  end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb_serial_tx_fifo: directed scenarios for serial_tx_fifo with CLK_PER_BIT=4
// and FIFO_DEPTH=4. Accepted bytes go into an expected queue; a line decoder
// pops and compares each byte as its frame completes.
module tb_serial_tx_fifo;

  localparam int CPB = 4;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] data     = 8'h00;
  logic       new_data = 1'b0;
  logic       block    = 1'b0;
  logic       tx_busy;
  logic       overflow;
  logic       tx;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         cyc       = 0;
  int         frames    = 0;
  bit         mon_busy  = 1'b0;
  int         mon_cnt   = 0;
  logic [7:0] mon_shift = 8'h00;
  int         base;

  serial_tx_fifo #(
    .CLK_PER_BIT(CPB),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .new_data(new_data),
    .block   (block),
    .tx_busy (tx_busy),
    .overflow(overflow),
    .tx      (tx)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Align to just after a rising edge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write strobe; call just after a rising edge
  task automatic applyStimulus(input logic [7:0] b, input bit accept);
    data     = b;
    new_data = 1'b1;
    if (accept) exp_q.push_back(b);
    @(posedge clk);
    #1;
    new_data = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (!(exp_q.size() == 0 && !mon_busy) && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (!(exp_q.size() == 0 && !mon_busy)) begin
      mismatched++;
      $display("[TB] FAIL wait_idle: %0d bytes still pending after %0d cycles", exp_q.size(), max_cycles);
    end
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
  endtask

  // Line decoder: frame start is the first low sample, bits sampled mid-period
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        frames++;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) checkOutput("start_bit", {31'd0, tx}, 32'd0);
      if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
        mon_shift[(mon_cnt - 6) / 4] = tx;
      if (mon_cnt == 38) checkOutput("stop_bit", {31'd0, tx}, 32'd1);
      if (mon_cnt == 39) begin
        mon_busy = 1'b0;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_frame: got byte %02h, expected none", mon_shift);
        end else begin
          checkOutput("rx_byte", {24'd0, mon_shift}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);

    // Single byte and write-to-line latency
    sync();
    applyStimulus(8'hB1, 1'b1);
    @(negedge clk);
    checkOutput("latency_pre", {31'd0, tx}, 32'd1);
    @(negedge clk);
    checkOutput("latency_start", {31'd0, tx}, 32'd0);
    wait_idle(100);
    checkOutput("single_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("single_idle_tx", {31'd0, tx}, 32'd1);

    // Burst of five, then a sixth write into a full FIFO
    sync();
    start_q.delete();
    applyStimulus(8'h68, 1'b1);
    applyStimulus(8'hB1, 1'b1);
    applyStimulus(8'h08, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("burst_busy_full", {31'd0, tx_busy}, 32'd1);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("overflow_set", {31'd0, overflow}, 32'd1);
    repeat (35) sync();
    checkOutput("busy_before_pop2", {31'd0, tx_busy}, 32'd1);
    sync();
    checkOutput("busy_after_pop2", {31'd0, tx_busy}, 32'd0);
    wait_idle(300);
    checkOutput("overflow_sticky", {31'd0, overflow}, 32'd1);
    checkOutput("burst_frames", start_q.size(), 32'd5);
    for (int i = 1; i < start_q.size(); i++)
      checkOutput("burst_gap", start_q[i] - start_q[i-1], 32'd40);

    do_reset();
    checkOutput("rst_overflow_clear", {31'd0, overflow}, 32'd0);
    checkOutput("rst_busy", {31'd0, tx_busy}, 32'd0);

    // Block: hold, release, reassert mid-frame
    sync();
    base  = frames;
    block = 1'b1;
    applyStimulus(8'h55, 1'b1);
    repeat (5) sync();
    checkOutput("blocked_tx", {31'd0, tx}, 32'd1);
    checkOutput("blocked_busy", {31'd0, tx_busy}, 32'd1);
    checkOutput("blocked_frames", frames - base, 32'd0);
    block = 1'b0;
    @(negedge clk);
    checkOutput("unblock_pre", {31'd0, tx}, 32'd1);
    @(negedge clk);
    checkOutput("unblock_start", {31'd0, tx}, 32'd0);
    sync();
    applyStimulus(8'hAA, 1'b1);
    repeat (10) sync();
    block = 1'b1;
    repeat (50) sync();
    checkOutput("reblock_frames", frames - base, 32'd1);
    checkOutput("reblock_tx", {31'd0, tx}, 32'd1);
    checkOutput("reblock_pending", exp_q.size(), 32'd1);
    block = 1'b0;
    wait_idle(100);

    // Reset during bit 3 of the first of three frames
    sync();
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    repeat (15) sync();
    exp_q.delete();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    checkOutput("midrst_tx", {31'd0, tx}, 32'd1);
    checkOutput("midrst_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("midrst_overflow", {31'd0, overflow}, 32'd0);
    base = frames;
    repeat (100) sync();
    checkOutput("midrst_no_frames", frames - base, 32'd0);
    checkOutput("midrst_idle_tx", {31'd0, tx}, 32'd1);

    // Boundary patterns all-zero then all-one, back-to-back
    sync();
    start_q.delete();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    wait_idle(200);
    checkOutput("boundary_frames", start_q.size(), 32'd2);
    for (int i = 1; i < start_q.size(); i++)
      checkOutput("boundary_gap", start_q[i] - start_q[i-1], 32'd40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_tx_fifo.md
# serial_tx_fifo

UART transmitter (8N1, LSB first) with a small input FIFO, placed directly downstream of `message_printer`. It consumes the printer's `tx_data`/`new_tx_data` byte stream and drives the serial line. It returns `tx_busy` so the printer holds off while the FIFO is full or the host blocks transmission.

## Interface
- `CLK_PER_BIT`, default 50: clock cycles per serial bit. Must be at least 2.
- `FIFO_DEPTH`, default 4: number of byte entries. Must be a power of 2 and at least 2.
- `clk` in, 1: system clock; all logic is on the rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `data` in, 8: byte to send; connects to the printer's `tx_data`.
- `new_data` in, 1: one-cycle write strobe for `data`; connects to `new_tx_data`.
- `block` in, 1: when high, no new frame may start.
- `tx_busy` out, 1: writes will be rejected; connects to the printer's `tx_busy`.
- `overflow` out, 1: sticky flag; a write was dropped.
- `tx` out, 1: serial line; idles high.

## Operation
- **FIFO write rule**
  - A write happens when `new_data`=1 and the FIFO is not full.
  - When the FIFO is full, the write is rejected even if a pop occurs in the same cycle.
  - A rejected write sets `overflow`=1. Only `rst` clears it.
- **FIFO structure**
  - Registered circular buffer with read pointer, write pointer and occupancy count.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - The count ranges 0..`FIFO_DEPTH`.
- **`tx_busy`** = (count == `FIFO_DEPTH`) OR `block`. It is combinational from registered count plus the `block` input.
- **State machine:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. When the FIFO is non-empty and `block`=0, pop the head into the shift register, clear the bit timer, and go to START.
  - START: `tx`=0 for `CLK_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLK_PER_BIT` cycles per bit. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: `tx`=1 for `CLK_PER_BIT` cycles.
    - On the last STOP cycle, if the FIFO is non-empty and `block`=0, pop and go directly to START (no gap).
    - Otherwise go to IDLE.
- **`block` behaviour**
  - `block` is sampled only at frame-start decisions: in IDLE, and on the last STOP cycle.
  - Asserting `block` mid-frame never truncates the frame in progress.
- **Counter widths:** bit timer is clog2(`CLK_PER_BIT`) bits; bit index is 3 bits.
- **Registered output:** `tx` is a register, so there are no glitches.
- **Reset**
  - Values after reset: `tx`=1, state IDLE, FIFO empty, `overflow`=0, `tx_busy`=`block`.
  - Reset mid-frame aborts the frame: `tx` is high from the next edge and all queued bytes are discarded.

## Timing
- **Write-to-line latency:** a write at edge E into an empty FIFO, while IDLE with `block`=0, is popped at edge E+1. `tx` is low from E+1 for `CLK_PER_BIT` cycles.
- **Frame length:** exactly 10×`CLK_PER_BIT` cycles. Back-to-back frames have a period of exactly 10×`CLK_PER_BIT`.
- **Unblocking:** when `block` falls while IDLE with data queued, START begins at the edge after the first cycle in which `block`=0.
- **`tx_busy` timing:** rises in the cycle after the write that fills the FIFO. It falls in the cycle after the pop that frees an entry.
- **Acceptance:** `new_data` is accepted on any cycle in which `tx_busy`'s full term is 0. No minimum spacing between writes.

## Test plan
All scenarios use `CLK_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Single byte:** write 8'hB1 once. `tx` is 0 for 4 cycles, then 1,0,0,0,1,1,0,1 (4 cycles each), then 1 for 4 cycles. Total 40 cycles, then idle high; `overflow`=0.
- **Burst:** write "h", B1, 08, 00, 00 on 5 consecutive cycles. All 5 are accepted and `tx_busy` goes high after the 5th. Five contiguous frames (200 cycles) decode to 68,B1,08,00,00 with no idle gap. `tx_busy` falls after the second pop.
- **Overflow:** same as Burst plus a 6th write of 8'hFF while `tx_busy`=1. `overflow`=1 and stays 1. The decoded stream is unchanged, with no FF.
- **Block:**
  - Hold `block`=1 and write 8'h55: `tx` stays 1 and `tx_busy`=1.
  - Release `block`: `tx` falls 1 edge later.
  - Reassert `block` at data bit 2: the frame completes as 55 and the queued 8'hAA does not start until `block`=0.
- **Reset mid-frame:** write 01,FF,FF, then pulse `rst` during bit 3 of the first frame. From the next edge: `tx`=1, `tx_busy`=0, `overflow`=0. No further frames appear within 100 cycles.
- **Boundary patterns:** write 8'h00, then 8'hFF. The frames are 0,00000000,1 and 0,11111111,1, back-to-back, 80 cycles total.
